// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes (also used by the ALU), RV32 opcode/funct7
// constants and the packed EX-stage control bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID -> EX issue bus: instruction in with valid/stall/flush, registered ALU control out.
interface alu_issue_stage_if #(
    parameter int CNT_W = 8
);
    // valid_i marks a real instruction on inst_i; it is consumed at the rising edge
    // unless stall_i (hold EX) or flush_i (bubble, dominates stall) is high. valid_o
    // marks a real instruction in EX; illegal_o pulses once per consumed illegal word.
    logic [31:0]      inst_i;
    logic             valid_i;
    logic             stall_i;
    logic             flush_i;
    logic [3:0]       ALUCtrl_o;
    logic             ALUSrc_o;
    logic             RegWrite_o;
    logic             MemtoReg_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             Branch_o;
    logic             valid_o;
    logic             illegal_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport master (
        output inst_i, valid_i, stall_i, flush_i,
        input  ALUCtrl_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        input  Branch_o, valid_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  inst_i, valid_i, stall_i, flush_i,
        output ALUCtrl_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        output Branch_o, valid_o, illegal_o, illegal_cnt_o
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational instruction decoder: ALU code, EX control bits and illegal flag.
// MUL decode is present only when ALU_ISSUE_MUL_EN is defined.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    output ex_ctrl_t    ctrl_o,
    output logic [3:0]  alu_code_o,
    output logic        illegal_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    assign w_unused = &{1'b0, inst_i[24:15], inst_i[11:7]};

    always_comb begin
        ctrl_o     = '0;
        alu_code_o = ALU_AND;
        illegal_o  = 1'b1;
        case (w_opcode)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    illegal_o = 1'b0;
                    case (w_funct3)
                        3'b111:  alu_code_o = ALU_AND;
                        3'b100:  alu_code_o = ALU_XOR;
                        3'b001:  alu_code_o = ALU_SLL;
                        3'b000:  alu_code_o = ALU_ADD;
                        default: illegal_o  = 1'b1;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    illegal_o  = 1'b0;
                    alu_code_o = ALU_SUB;
                end
`ifdef ALU_ISSUE_MUL_EN
                else if (w_funct7 == F7_MULDIV && w_funct3 == 3'b000) begin
                    illegal_o  = 1'b0;
                    alu_code_o = ALU_MUL;
                end
`endif
            end
            OP_I: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                if (w_funct3 == 3'b000) begin
                    illegal_o  = 1'b0;
                    alu_code_o = ALU_ADDI;
                end else if (w_funct3 == 3'b101 && w_funct7 == F7_ALT) begin
                    illegal_o  = 1'b0;
                    alu_code_o = ALU_SRAI;
                end
            end
            OP_LOAD: begin
                illegal_o  = (w_funct3 != 3'b010);
                alu_code_o = ALU_LW;
                ctrl_o     = '{alu_src: 1'b1, reg_write: 1'b1, mem_to_reg: 1'b1,
                               mem_read: 1'b1, default: 1'b0};
            end
            OP_STORE: begin
                illegal_o  = (w_funct3 != 3'b010);
                alu_code_o = ALU_SW;
                ctrl_o     = '{alu_src: 1'b1, mem_write: 1'b1, default: 1'b0};
            end
            OP_BRANCH: begin
                illegal_o  = (w_funct3 != 3'b000);
                alu_code_o = ALU_BEQ;
                ctrl_o     = '{branch: 1'b1, default: 1'b0};
            end
            default: ;
        endcase
        // Illegal words must look exactly like a bubble downstream.
        if (illegal_o) begin
            ctrl_o     = '0;
            alu_code_o = ALU_AND;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX control slice: registers decoded ALU control with flush > stall > accept
// priority and keeps a saturating illegal-instruction count. Option: ALU_ISSUE_MUL_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_issue_stage_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_ctrl_t         w_dec_ctrl;
    logic [3:0]       w_dec_alu;
    logic             w_dec_illegal;

    ex_ctrl_t         r_ctrl;
    logic [3:0]       r_alu;
    logic             r_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    alu_ctrl_dec u_dec (
        .inst_i     (bus.inst_i),
        .ctrl_o     (w_dec_ctrl),
        .alu_code_o (w_dec_alu),
        .illegal_o  (w_dec_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl    <= '0;
            r_alu     <= ALU_AND;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_illegal <= 1'b0;
            if (bus.flush_i) begin
                r_ctrl  <= '0;
                r_alu   <= ALU_AND;
                r_valid <= 1'b0;
            end else if (!bus.stall_i) begin
                if (bus.valid_i && !w_dec_illegal) begin
                    r_ctrl  <= w_dec_ctrl;
                    r_alu   <= w_dec_alu;
                    r_valid <= 1'b1;
                end else begin
                    r_ctrl  <= '0;
                    r_alu   <= ALU_AND;
                    r_valid <= 1'b0;
                    if (bus.valid_i) begin
                        r_illegal <= 1'b1;
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ALUCtrl_o     = r_alu;
    assign bus.ALUSrc_o      = r_ctrl.alu_src;
    assign bus.RegWrite_o    = r_ctrl.reg_write;
    assign bus.MemtoReg_o    = r_ctrl.mem_to_reg;
    assign bus.MemRead_o     = r_ctrl.mem_read;
    assign bus.MemWrite_o    = r_ctrl.mem_write;
    assign bus.Branch_o      = r_ctrl.branch;
    assign bus.valid_o       = r_valid;
    assign bus.illegal_o     = r_illegal;
    assign bus.illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: an 8-bit-counter instance and a 2-bit-counter
// instance share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_alu_issue_stage;

    // ctrl pattern order: {ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_R    = 6'b010000;
    localparam logic [5:0] C_I    = 6'b110000;
    localparam logic [5:0] C_LW   = 6'b111100;
    localparam logic [5:0] C_SW   = 6'b100010;
    localparam logic [5:0] C_BR   = 6'b000001;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4030D213;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;
    localparam logic [31:0] I_SLL  = 32'h002091B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_SRLI = 32'h0030D213;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
    localparam logic [31:0] I_ZERO = 32'h00000000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.CNT_W(8)) bus8 ();
    alu_issue_stage_if #(.CNT_W(2)) bus2 ();

    alu_issue_stage #(.CNT_W(8)) u_dut (.clk_i(clk), .rst_i(rst_n), .bus(bus8));
    alu_issue_stage #(.CNT_W(2)) u_sat (.clk_i(clk), .rst_i(rst_n), .bus(bus2));

    // {alu[3:0], ctrl[5:0], valid, illegal, cnt8[7:0], cnt2[1:0]}
    logic [21:0] exp_q[$];
    string       name_q[$];
    logic [21:0] w_act;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  m_cnt8 = '0;
    logic [1:0]  m_cnt2 = '0;

    assign w_act = {bus8.ALUCtrl_o, bus8.ALUSrc_o, bus8.RegWrite_o, bus8.MemtoReg_o,
                    bus8.MemRead_o, bus8.MemWrite_o, bus8.Branch_o, bus8.valid_o,
                    bus8.illegal_o, bus8.illegal_cnt_o, bus2.illegal_cnt_o};

    task automatic set_inputs(input logic [31:0] inst, input logic v, input logic st,
                              input logic fl);
        bus8.inst_i = inst; bus8.valid_i = v; bus8.stall_i = st; bus8.flush_i = fl;
        bus2.inst_i = inst; bus2.valid_i = v; bus2.stall_i = st; bus2.flush_i = fl;
    endtask

    task automatic drive(input string name, input logic [31:0] inst, input logic v,
                         input logic st, input logic fl, input logic [3:0] e_alu,
                         input logic [5:0] e_ctrl, input logic e_v, input logic e_ill);
        @(negedge clk);
        set_inputs(inst, v, st, fl);
        if (e_ill) begin
            if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
            if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
        end
        exp_q.push_back({e_alu, e_ctrl, e_v, e_ill, m_cnt8, m_cnt2});
        name_q.push_back(name);
    endtask

    task automatic check_now(input string name, input logic [21:0] e);
        n_cmp++;
        if (w_act !== e) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h", name, w_act, e);
        end
    endtask

    // Monitor: one registered result per driven cycle, checked just after the edge.
    initial begin
        logic [21:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check_now(nm, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int waits;
        rst_n = 1'b0;
        set_inputs(I_ADD, 1'b1, 1'b0, 1'b0);
        #3;
        check_now("reset_t0", 22'h0);
        repeat (2) @(posedge clk);
        #2;
        check_now("reset_clocked", 22'h0);
        @(negedge clk);
        set_inputs(I_ZERO, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        drive("add",   I_ADD,  1, 0, 0, 4'b0011, C_R,  1, 0);
        drive("sub",   I_SUB,  1, 0, 0, 4'b0100, C_R,  1, 0);
        drive("srai",  I_SRAI, 1, 0, 0, 4'b0111, C_I,  1, 0);
        drive("lw",    I_LW,   1, 0, 0, 4'b1000, C_LW, 1, 0);
        drive("and",   I_AND,  1, 0, 0, 4'b0000, C_R,  1, 0);
        drive("xor",   I_XOR,  1, 0, 0, 4'b0001, C_R,  1, 0);
        drive("sll",   I_SLL,  1, 0, 0, 4'b0010, C_R,  1, 0);
        drive("addi",  I_ADDI, 1, 0, 0, 4'b0110, C_I,  1, 0);
        drive("sw",    I_SW,   1, 0, 0, 4'b1001, C_SW, 1, 0);
        drive("beq",   I_BEQ,  1, 0, 0, 4'b1010, C_BR, 1, 0);
        drive("idle",  I_ADD,  0, 0, 0, 4'b0000, C_NONE, 0, 0);

        drive("lw2",         I_LW,  1, 0, 0, 4'b1000, C_LW, 1, 0);
        drive("stall1",      I_SUB, 1, 1, 0, 4'b1000, C_LW, 1, 0);
        drive("stall2",      I_SUB, 1, 1, 0, 4'b1000, C_LW, 1, 0);
        drive("stall3",      I_SUB, 1, 1, 0, 4'b1000, C_LW, 1, 0);
        drive("stall_flush", I_SUB, 1, 1, 1, 4'b0000, C_NONE, 0, 0);

        drive("ill1",      I_ONES, 1, 0, 0, 4'b0000, C_NONE, 0, 1);
        drive("ill2",      I_ONES, 1, 0, 0, 4'b0000, C_NONE, 0, 1);
        drive("ill_stall", I_ONES, 1, 1, 0, 4'b0000, C_NONE, 0, 0);
        drive("ill_flush", I_ONES, 1, 0, 1, 4'b0000, C_NONE, 0, 0);
        drive("srli_ill",  I_SRLI, 1, 0, 0, 4'b0000, C_NONE, 0, 1);
        drive("zero_ill",  I_ZERO, 1, 0, 0, 4'b0000, C_NONE, 0, 1);
        drive("ill5_sat",  I_ONES, 1, 0, 0, 4'b0000, C_NONE, 0, 1);
`ifdef ALU_ISSUE_MUL_EN
        drive("mul",       I_MUL,  1, 0, 0, 4'b0101, C_R,    1, 0);
`else
        drive("mul_ill",   I_MUL,  1, 0, 0, 4'b0000, C_NONE, 0, 1);
`endif
        drive("add_after",       I_ADD,  1, 0, 0, 4'b0011, C_R,    1, 0);
        drive("ill_flush_stall", I_ONES, 1, 1, 1, 4'b0000, C_NONE, 0, 0);
        drive("idle_ill_word",   I_ONES, 0, 0, 0, 4'b0000, C_NONE, 0, 0);

        drive("lw3",      I_LW,  1, 0, 0, 4'b1000, C_LW, 1, 0);
        drive("stall_lw", I_SUB, 1, 1, 0, 4'b1000, C_LW, 1, 0);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        m_cnt8 = '0;
        m_cnt2 = '0;
        #1;
        check_now("reset_mid_stall", 22'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst_stall", I_SUB, 1, 1, 0, 4'b0000, C_NONE, 0, 0);
        drive("post_rst_add",   I_ADD, 1, 0, 0, 4'b0011, C_R,    1, 0);
        drive("post_rst_ill",   I_ONES, 1, 0, 0, 4'b0000, C_NONE, 0, 1);

        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
